// File: rtl/deco_lectura.sv
// deco_lectura: reads the nine RTC registers over the bus controller, validates each BCD byte and keeps binary copies.
// Optional build macro DECO_LECTURA_RANGE_CHK_EN adds per-field range checks on top of the nibble check.
module deco_lectura #(
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       pausa,
   input  logic       ack,
   input  logic [7:0] dato_rtc,
   output logic       rd_req,
   output logic [7:0] direccion,
   output logic       busy,
   output logic       done,
   output logic       err_bcd,
   output logic       err_timeout,
   output logic [6:0] hora,
   output logic [6:0] minuto,
   output logic [6:0] segundo,
   output logic [6:0] dia,
   output logic [6:0] mes,
   output logic [6:0] anio,
   output logic [6:0] t_hora,
   output logic [6:0] t_minuto,
   output logic [6:0] t_segundo
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ESPERA = 3'd1,
      CONV   = 3'd2,
      PAUSA  = 3'd3,
      FIN    = 3'd4
   } state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t      state_r, state_nx_s;
   logic [3:0]  idx_r, idx_nx_s;
   logic [15:0] cnt_r;
   logic [7:0]  dato_r;
   logic [6:0]  val_r [0:8];
   logic        rd_req_nx_s, busy_nx_s, done_nx_s;
   logic [7:0]  dir_nx_s;
   logic        timeout_s, byte_ok_s, offset_s;
   logic [6:0]  bin_s;

   function automatic logic [7:0] addr_of(input logic [3:0] i);
      logic [7:0] a;
      case (i)
         4'd0:    a = 8'h23;
         4'd1:    a = 8'h22;
         4'd2:    a = 8'h21;
         4'd3:    a = 8'h24;
         4'd4:    a = 8'h25;
         4'd5:    a = 8'h26;
         4'd6:    a = 8'h43;
         4'd7:    a = 8'h42;
         4'd8:    a = 8'h41;
         default: a = 8'hFF;
      endcase
      return a;
   endfunction

   function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
      logic [6:0] hi;
      hi = {3'd0, b[7:4]};
      return (hi << 3) + (hi << 1) + {3'd0, b[3:0]};
   endfunction

   // Nibble check, dia/mes zero check and optional range check; ranges compare the raw BCD byte.
   function automatic logic byte_ok(input logic [7:0] b, input logic [3:0] i);
      logic       ok;
      logic [7:0] lim;
      ok  = (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
      ok  = ok && !(((i == 4'd3) || (i == 4'd4)) && (b == 8'h00));
      case (i)
         4'd0, 4'd6: lim = 8'h23;
         4'd3:       lim = 8'h31;
         4'd4:       lim = 8'h12;
         4'd5:       lim = 8'h99;
         default:    lim = 8'h59;
      endcase
`ifdef DECO_LECTURA_RANGE_CHK_EN
      ok = ok && (b <= lim);
`else
      ok = ok && (lim != 8'h00);
`endif
      return ok;
   endfunction

   assign timeout_s = (state_r == ESPERA) && !ack && (cnt_r >= TO_LAST);
   assign offset_s  = (idx_r == 4'd3) || (idx_r == 4'd4);
   assign byte_ok_s = byte_ok(dato_r, idx_r);
   assign bin_s     = bcd_to_bin(dato_r) - (offset_s ? 7'd1 : 7'd0);

   // State and index register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         idx_r   <= 4'd0;
      end else begin
         state_r <= state_nx_s;
         idx_r   <= idx_nx_s;
      end
   end

   // Next-state and next-index logic.
   always_comb begin
      state_nx_s = state_r;
      idx_nx_s   = idx_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx_s = pausa ? PAUSA : ESPERA;
               idx_nx_s   = 4'd0;
            end else begin
               state_nx_s = IDLE;
            end
         end
         ESPERA: begin
            if (ack) begin
               state_nx_s = CONV;
            end else if (timeout_s) begin
               state_nx_s = FIN;
            end else begin
               state_nx_s = ESPERA;
            end
         end
         CONV: begin
            if (idx_r == 4'd8) begin
               state_nx_s = FIN;
            end else begin
               state_nx_s = pausa ? PAUSA : ESPERA;
               idx_nx_s   = idx_r + 4'd1;
            end
         end
         PAUSA: begin
            if (!pausa) begin
               state_nx_s = ESPERA;
            end else begin
               state_nx_s = PAUSA;
            end
         end
         FIN:     state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // Next values of the handshake/status outputs, derived from where the FSM is heading.
   always_comb begin
      rd_req_nx_s = (state_nx_s == ESPERA);
      busy_nx_s   = (state_nx_s != IDLE);
      done_nx_s   = (state_nx_s == FIN);
      if (state_nx_s == ESPERA) begin
         dir_nx_s = addr_of(idx_nx_s);
      end else begin
         dir_nx_s = 8'hFF;
      end
   end

   // Registered handshake/status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_req    <= 1'b0;
         direccion <= 8'hFF;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         rd_req    <= rd_req_nx_s;
         direccion <= dir_nx_s;
         busy      <= busy_nx_s;
         done      <= done_nx_s;
      end
   end

   // Datapath: ack-wait counter, captured byte, sticky errors and the nine value registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r       <= 16'd0;
         dato_r      <= 8'd0;
         err_bcd     <= 1'b0;
         err_timeout <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            val_r[i] <= 7'd0;
         end
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  cnt_r       <= 16'd0;
                  err_bcd     <= 1'b0;
                  err_timeout <= 1'b0;
               end
            end
            ESPERA: begin
               cnt_r <= cnt_r + 16'd1;
               if (ack) begin
                  dato_r <= dato_rtc;
               end else if (timeout_s) begin
                  err_timeout <= 1'b1;
               end
            end
            CONV: begin
               cnt_r <= 16'd0;
               if (byte_ok_s) begin
                  val_r[idx_r] <= bin_s;
               end else begin
                  err_bcd <= 1'b1;
               end
            end
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   assign hora      = val_r[0];
   assign minuto    = val_r[1];
   assign segundo   = val_r[2];
   assign dia       = val_r[3];
   assign mes       = val_r[4];
   assign anio      = val_r[5];
   assign t_hora    = val_r[6];
   assign t_minuto  = val_r[7];
   assign t_segundo = val_r[8];
endmodule

// File: tb/tb_deco_lectura.sv
// tb_deco_lectura: directed and randomized read sequences checked against a behavioural model of the decoder.
`timescale 1ns/1ps
module tb_deco_lectura;
   localparam int TO = 8;

   logic       clk, reset, start, pausa, ack;
   logic [7:0] dato_rtc, direccion;
   logic       rd_req, busy, done, err_bcd, err_timeout;
   logic [6:0] obs [9];

   int         total, bad;
   logic [7:0] bytes_g [9];
   logic [6:0] exp_val [9];
   logic       exp_ebcd, exp_eto;
   logic [7:0] addr_tab [9] = '{8'h23, 8'h22, 8'h21, 8'h24, 8'h25, 8'h26, 8'h43, 8'h42, 8'h41};

   deco_lectura #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .pausa(pausa), .ack(ack), .dato_rtc(dato_rtc),
      .rd_req(rd_req), .direccion(direccion), .busy(busy), .done(done),
      .err_bcd(err_bcd), .err_timeout(err_timeout),
      .hora(obs[0]), .minuto(obs[1]), .segundo(obs[2]), .dia(obs[3]), .mes(obs[4]), .anio(obs[5]),
      .t_hora(obs[6]), .t_minuto(obs[7]), .t_segundo(obs[8])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic int lim_of(input int i);
      case (i)
         0, 6:    return 23;
         3:       return 31;
         4:       return 12;
         5:       return 99;
         default: return 59;
      endcase
   endfunction

   // Reference conversion straight from the field rules: decimal digits, day/month offset.
   function automatic bit model_conv(input logic [7:0] b, input int i, output logic [6:0] v);
      int hi, lo, n;
      hi = int'(b) / 16;
      lo = int'(b) % 16;
      n  = hi * 10 + lo;
      v  = 7'd0;
      if (hi > 9 || lo > 9) return 1'b0;
      if ((i == 3 || i == 4) && n == 0) return 1'b0;
`ifdef DECO_LECTURA_RANGE_CHK_EN
      if (n > lim_of(i)) return 1'b0;
`endif
      v = 7'((i == 3 || i == 4) ? n - 1 : n);
      return 1'b1;
   endfunction

   function automatic logic [7:0] rand_byte(input int i);
      int n;
      if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
      n = (i == 3 || i == 4) ? int'($urandom_range(1, lim_of(i))) : int'($urandom_range(0, lim_of(i)));
      return 8'((n / 10) * 16 + n % 10);
   endfunction

   task automatic check_state(input string tag);
      chk({tag, "_rd_req"}, 32'(rd_req), 32'(1'b0));
      chk({tag, "_dir"}, 32'(direccion), 32'(8'hFF));
      chk({tag, "_busy"}, 32'(busy), 32'(1'b0));
      chk({tag, "_done"}, 32'(done), 32'(1'b0));
      chk({tag, "_err_bcd"}, 32'(err_bcd), 32'(exp_ebcd));
      chk({tag, "_err_to"}, 32'(err_timeout), 32'(exp_eto));
      for (int i = 0; i < 9; i++) chk($sformatf("%s_val%0d", tag, i), 32'(obs[i]), 32'(exp_val[i]));
   endtask

   // One full sequence: acks every request in its first cycle except at drop_idx, optional pausa hold after hold_idx.
   task automatic run_seq(input int drop_idx, input int hold_idx, input int hold_len, input bit restart);
      int cyc, done_cyc, hold_left, hi_cnt, exp_done, cur, acked_idx;
      bit acked_prev;
      logic rd_prev;
      logic [7:0] seen [$];
      logic [6:0] v;
      cyc = 0; done_cyc = -1; hold_left = 0; hi_cnt = 0; acked_prev = 1'b0; acked_idx = -1; rd_prev = 1'b0;
      @(negedge clk);
      start = 1'b1; pausa = 1'b0;
      @(negedge clk);
      while (done_cyc < 0 && cyc < 300) begin
         cyc++;
         start = restart && (cyc == 4);
         cur = -1;
         for (int k = 0; k < 9; k++) if (addr_tab[k] == direccion) cur = k;
         if (rd_req && !rd_prev) seen.push_back(direccion);
         if (rd_req && cur == drop_idx) hi_cnt++;
         if (acked_prev && acked_idx == hold_idx) hold_left = hold_len;
         if (hold_left > 0) begin
            pausa = 1'b1;
            hold_left--;
            chk("hold_rd_req", 32'(rd_req), 32'(1'b0));
            chk("hold_dir", 32'(direccion), 32'(8'hFF));
         end else begin
            pausa = 1'b0;
         end
         acked_prev = rd_req && (cur >= 0) && (cur != drop_idx);
         acked_idx  = cur;
         ack        = acked_prev;
         dato_rtc   = acked_prev ? bytes_g[cur] : 8'($urandom);
         rd_prev    = rd_req;
         if (done) begin
            done_cyc = cyc;
            chk("busy_at_done", 32'(busy), 32'(1'b1));
         end else begin
            @(negedge clk);
         end
      end
      ack = 1'b0; pausa = 1'b0; start = 1'b0;

      exp_ebcd = 1'b0;
      exp_eto  = (drop_idx < 9);
      for (int i = 0; i < 9 && i < drop_idx; i++) begin
         if (model_conv(bytes_g[i], i, v)) exp_val[i] = v;
         else exp_ebcd = 1'b1;
      end
      exp_done = ((drop_idx < 9) ? 2 * drop_idx + 1 + TO : 19) +
                 ((hold_idx >= 0 && hold_idx < 8 && hold_idx < drop_idx) ? hold_len : 0);
      chk("done_cycle", 32'(done_cyc), 32'(exp_done));
      chk("n_requests", 32'(seen.size()), 32'((drop_idx < 9) ? drop_idx + 1 : 9));
      for (int i = 0; i < seen.size() && i < 9; i++) chk($sformatf("addr%0d", i), 32'(seen[i]), 32'(addr_tab[i]));
      if (drop_idx < 9) chk("timeout_req_cycles", 32'(hi_cnt), 32'(TO));
      @(negedge clk);
      check_state("after_seq");
   endtask

   initial begin
      int drop, hold;
      total = 0; bad = 0;
      reset = 1'b1; start = 1'b0; pausa = 1'b0; ack = 1'b0; dato_rtc = 8'h00;
      for (int i = 0; i < 9; i++) exp_val[i] = 7'd0;
      exp_ebcd = 1'b0; exp_eto = 1'b0;
      repeat (2) @(negedge clk);
      check_state("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_state("idle");

      bytes_g = '{8'h12, 8'h34, 8'h56, 8'h15, 8'h08, 8'h16, 8'h01, 8'h02, 8'h03};
      run_seq(9, -1, 0, 1'b0);
      chk("nominal_hora", 32'(obs[0]), 32'd12);
      chk("nominal_dia", 32'(obs[3]), 32'd14);
      chk("nominal_mes", 32'(obs[4]), 32'd7);
      chk("nominal_tseg", 32'(obs[8]), 32'd3);

      // Bad BCD for minuto; a start pulse mid-sequence must be ignored.
      bytes_g = '{8'h07, 8'h5A, 8'h09, 8'h28, 8'h11, 8'h24, 8'h05, 8'h06, 8'h07};
      run_seq(9, -1, 0, 1'b1);
      chk("badbcd_minuto_kept", 32'(obs[1]), 32'd34);
      chk("badbcd_err", 32'(err_bcd), 32'd1);

      bytes_g = '{8'h21, 8'h45, 8'h33, 8'h01, 8'h09, 8'h30, 8'h10, 8'h20, 8'h30};
      run_seq(4, -1, 0, 1'b0);
      chk("timeout_mes_kept", 32'(obs[4]), 32'd10);

      bytes_g = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10};
      run_seq(9, 2, 5, 1'b0);

      bytes_g = '{8'h25, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
      run_seq(9, -1, 0, 1'b0);
`ifdef DECO_LECTURA_RANGE_CHK_EN
      chk("hora25", 32'(obs[0]), 32'd2);
      chk("hora25_err", 32'(err_bcd), 32'd1);
`else
      chk("hora25", 32'(obs[0]), 32'd25);
      chk("hora25_err", 32'(err_bcd), 32'd0);
`endif

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 9; i++) bytes_g[i] = rand_byte(i);
         drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : 9;
         hold = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
         run_seq(drop, hold, int'($urandom_range(1, 4)), 1'b0);
      end

      // Asynchronous reset in the middle of a sequence.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 7; c++) begin
         ack = rd_req;
         dato_rtc = 8'h11;
         @(negedge clk);
      end
      #2 reset = 1'b1;
      ack = 1'b0;
      for (int i = 0; i < 9; i++) exp_val[i] = 7'd0;
      exp_ebcd = 1'b0; exp_eto = 1'b0;
      #1 check_state("async_reset");
      @(negedge clk);
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/deco_lectura.md
Name: deco_lectura

Overview:
- Read-side counterpart of the RTC write decoder: sequences reads of the nine RTC registers over the shared address/data bus controller.
- Captures each returned BCD byte, validates it and converts it to binary. Day/month are undone from the write side's +1 offset.
- Holds the results as stable binary registers for the display and edit logic.
- Sits between the bus controller (req/ack handshake) and the time-keeping/control FSM (start/done).

Parameters:
- TIMEOUT, 255, max cycles waited for ack per register before abort (1..65535; 16-bit counter).

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- start  input  1  one-cycle pulse; begins a full read sequence; ignored unless IDLE
- pausa  input  1  high = do not issue the next bus request (hold between registers)
- ack  input  1  bus controller: dato_rtc valid this cycle; ignored outside ESPERA
- dato_rtc  input  8  BCD byte read from the RTC
- rd_req  output  1  read request, level, held until ack or timeout
- direccion  output  8  RTC address for the current request; 8'hFF when idle
- busy  output  1  high from cycle after accepted start until FIN exits
- done  output  1  one-cycle pulse at end of sequence (normal or aborted)
- err_bcd  output  1  sticky; a byte failed validation; cleared on accepted start
- err_timeout  output  1  sticky; sequence aborted on timeout; cleared on accepted start
- hora, minuto, segundo, dia, mes, anio  output  7 each  binary time/date
- t_hora, t_minuto, t_segundo  output  7 each  binary timer

Behaviour:
- Reset: rd_req=0, direccion=8'hFF, busy=0, done=0, err_*=0, all nine value registers=0, idx=0, state IDLE.
- Index table, idx 0..8 -> address, target:
  - 0 -> 0x23, hora
  - 1 -> 0x22, minuto
  - 2 -> 0x21, segundo
  - 3 -> 0x24, dia
  - 4 -> 0x25, mes
  - 5 -> 0x26, anio
  - 6 -> 0x43, t_hora
  - 7 -> 0x42, t_minuto
  - 8 -> 0x41, t_segundo
- FSM states: IDLE, ESPERA, CONV, PAUSA, FIN.
  - IDLE: on start -> idx=0, clear err_*, timeout counter=0, go ESPERA if pausa=0, else PAUSA.
  - ESPERA: rd_req=1, direccion=table[idx], counter increments each cycle.
    - ack=1: latch dato_rtc, go CONV.
    - Otherwise, counter reaches TIMEOUT: err_timeout=1, rd_req drops, go FIN. Remaining registers keep old values.
  - CONV: one cycle, rd_req=0. Validate and convert, write target register if valid. If idx==8 go FIN; else idx+1, counter=0, then ESPERA if pausa=0, else PAUSA.
  - PAUSA: rd_req=0, direccion=8'hFF; go ESPERA when pausa=0.
  - FIN: done=1 for one cycle, direccion=8'hFF, busy=0 next cycle, go IDLE.
- Conversion: bin = 10*hi_nibble + lo_nibble, 7 bits.
  - Either nibble >9: err_bcd=1, target unchanged, sequence continues.
  - idx 3,4 (dia, mes): stored value = bin-1. A BCD value of 00 is invalid: err_bcd=1, target unchanged.
- Latency: with ack in the first ESPERA cycle and pausa=0, each register takes 2 cycles. done rises 19 cycles after the start cycle.
- ack and timeout in the same cycle: ack wins.
- start during busy: ignored. Reset mid-sequence: immediate return to reset values; partially read registers are also cleared.

Optional Feature:
- DECO_LECTURA_RANGE_CHK_EN
  - Defined: after BCD check, a range check also applies. Out of range sets err_bcd and leaves the target unchanged. Ranges:
    - hora, t_hora 0..23
    - minuto, segundo, t_minuto, t_segundo 0..59
    - dia BCD 01..31
    - mes BCD 01..12
    - anio 0..99
  - Not defined: only the nibble check and the dia/mes 00 check apply.

Test Plan:
- Reset then idle: direccion=8'hFF, rd_req=0, all values 0.
- start; ack each ESPERA first cycle with bytes 12,34,56,15,08,16,01,02,03 (BCD hex), pausa=0:
  - addresses 23,22,21,24,25,26,43,42,41 in order
  - hora=12, minuto=34, segundo=56, dia=14, mes=7, anio=16, t_hora=1, t_minuto=2, t_segundo=3
  - done 19 cycles after start; err_*=0
- Return 0x5A for idx 1: err_bcd=1, minuto keeps prior value, remaining registers update, done pulses.
- Withhold ack at idx 4 with TIMEOUT=8: rd_req high 8 cycles, then err_timeout=1, done pulse; mes, anio and timer registers unchanged.
- Hold pausa=1 after idx 2 CONV for 5 cycles: rd_req=0, direccion=8'hFF during the hold; resumes at 0x24; done delayed exactly 5 cycles. Also assert reset in the middle of the next sequence and check all outputs return to reset values asynchronously.
- With DECO_LECTURA_RANGE_CHK_EN, return 0x25 for hora: err_bcd=1, hora unchanged. Without the macro, the same stimulus gives hora=25, err_bcd=0.
